// File: rtl/muldiv_unit.sv
// muldiv_unit: execute-stage multiply/divide engine owning the HI/LO pair.
//   Signed MULT (shift-add) and DIV (restoring) run one bit per cycle on
//   operand magnitudes; signs are applied and HI/LO committed in FIX.
//   Optional build macro MULDIV_FAST_MULT_EN: MULT uses a single-cycle
//   combinational multiplier and goes straight from IDLE to FIX.
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-low reset, clears all state
//   start       op valid this cycle (E stage not stalled)
//   alucontrol  4'b1000 MULT, 4'b1001 DIV, anything else ignored
//   hien/loen   commit HI / LO when the operation finishes
//   srca/srcb   rs / rt operands (multiplicand|dividend, multiplier|divisor)
//   flush       abort in-flight operation without writing HI/LO
//   busy        operation in flight (registered)
//   done        one-cycle pulse in the cycle HI/LO take their new values
//   hi/lo       HI and LO registers
module muldiv_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNTW  = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       alucontrol,
  input  logic             hien,
  input  logic             loen,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned     PW      = 2 * WIDTH;
  localparam logic [3:0]      OP_MULT = 4'b1000;
  localparam logic [3:0]      OP_DIV  = 4'b1001;
  localparam logic [CNTW-1:0] LAST    = CNTW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t            state;
  logic [WIDTH-1:0]  acc;      // product upper half / partial remainder
  logic [WIDTH-1:0]  mq;       // multiplier -> product lower half / dividend -> quotient
  logic [WIDTH-1:0]  opnd;     // multiplicand magnitude / divisor magnitude
  logic [CNTW-1:0]   cnt;
  logic              sign_a;
  logic              sign_b;
  logic              hien_q;
  logic              loen_q;
  logic              op_div;
  logic              div_zero;

  logic [WIDTH-1:0]  mag_a;
  logic [WIDTH-1:0]  mag_b;
  logic [WIDTH:0]    mul_sum;
  logic [WIDTH:0]    div_shift;
  logic [WIDTH-1:0]  div_diff;
  logic              div_ge;
  logic [PW-1:0]     prod;
  logic [PW-1:0]     prod_signed;
  logic [WIDTH-1:0]  quot_signed;
  logic [WIDTH-1:0]  rem_signed;
  logic              accept;

  always_comb begin
    // Unsigned WIDTH-bit magnitudes: |INT_MIN| = 2**(WIDTH-1) is representable,
    // and the shift-add/restoring datapaths carry their extra bit in mul_sum
    // and div_shift, so nothing overflows internally.
    mag_a       = srca[WIDTH-1] ? -srca : srca;
    mag_b       = srcb[WIDTH-1] ? -srcb : srcb;
    accept      = start && !flush && (alucontrol == OP_MULT || alucontrol == OP_DIV);

    mul_sum     = {1'b0, acc} + (mq[0] ? {1'b0, opnd} : '0);

    div_shift   = {acc, mq[WIDTH-1]};
    div_ge      = (div_shift >= {1'b0, opnd});
    // Only used when div_ge holds, so the true difference is < opnd and
    // fits in WIDTH bits.
    div_diff    = div_shift[WIDTH-1:0] - opnd;

    prod        = {acc, mq};
    prod_signed = (sign_a ^ sign_b) ? -prod : prod;
    quot_signed = (sign_a ^ sign_b) ? -mq : mq;
    rem_signed  = sign_a ? -acc : acc;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      acc      <= '0;
      mq       <= '0;
      opnd     <= '0;
      cnt      <= '0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      hien_q   <= 1'b0;
      loen_q   <= 1'b0;
      op_div   <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            sign_a   <= srca[WIDTH-1];
            sign_b   <= srcb[WIDTH-1];
            hien_q   <= hien;
            loen_q   <= loen;
            op_div   <= (alucontrol == OP_DIV);
            div_zero <= (srcb == '0);
            cnt      <= '0;
            busy     <= 1'b1;
            if (alucontrol == OP_DIV) begin
              acc   <= '0;
              mq    <= mag_a;
              opnd  <= mag_b;
              state <= DIV;
            end else begin
`ifdef MULDIV_FAST_MULT_EN
              {acc, mq} <= PW'(mag_a) * PW'(mag_b);
              opnd      <= mag_a;
              state     <= FIX;
`else
              acc   <= '0;
              mq    <= mag_b;
              opnd  <= mag_a;
              state <= MUL;
`endif
            end
          end
        end

        MUL: begin
          if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            // Add multiplicand if the current multiplier LSB is set, then
            // shift the {acc, mq} pair right; the carry lands in acc's MSB.
            acc <= mul_sum[WIDTH:1];
            mq  <= {mul_sum[0], mq[WIDTH-1:1]};
            cnt <= cnt + CNTW'(1);
            if (cnt == LAST) state <= FIX;
          end
        end

        DIV: begin
          if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            // Restoring step: keep the subtraction only when it does not borrow;
            // the quotient bit shifts into mq as the dividend bits shift out.
            acc <= div_ge ? div_diff : div_shift[WIDTH-1:0];
            mq  <= {mq[WIDTH-2:0], div_ge};
            cnt <= cnt + CNTW'(1);
            if (cnt == LAST) state <= FIX;
          end
        end

        FIX: begin
          if (!flush) begin
            if (hien_q) hi <= op_div ? rem_signed : prod_signed[PW-1:WIDTH];
            if (loen_q) lo <= op_div ? (div_zero ? '1 : quot_signed)
                                     : prod_signed[WIDTH-1:0];
            done <= 1'b1;
          end
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  localparam int W = 32;
  localparam logic [3:0] OP_MULT = 4'b1000;
  localparam logic [3:0] OP_DIV  = 4'b1001;
`ifdef MULDIV_FAST_MULT_EN
  localparam int MUL_LAT = 1;
  localparam logic [3:0] LONG_OP = OP_DIV;
`else
  localparam int MUL_LAT = W + 1;
  localparam logic [3:0] LONG_OP = OP_MULT;
`endif
  localparam int DIV_LAT = W + 1;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   alucontrol = '0;
  logic         hien = 1'b0;
  logic         loen = 1'b0;
  logic [W-1:0] srca = '0;
  logic [W-1:0] srcb = '0;
  logic         flush = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_hi = '0;
  logic [W-1:0] exp_lo = '0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W), .CNTW(6)) dut (
    .clk(clk), .reset(reset), .start(start), .alucontrol(alucontrol),
    .hien(hien), .loen(loen), .srca(srca), .srcb(srcb), .flush(flush),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference model: architectural signed MULT/DIV semantics with 64-bit math.
  function automatic void model_op(input logic [3:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic he, input logic le);
    longint sa, sb, p, q, r;
    logic [63:0] pu;
    logic [W-1:0] rh, rl;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op == OP_MULT) begin
      p  = sa * sb;
      pu = p;
      rh = pu[63:32];
      rl = pu[31:0];
    end else if (b == '0) begin
      rh = a;
      rl = '1;
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      rh = r[W-1:0];
      rl = q[W-1:0];
    end
    if (he) exp_hi = rh;
    if (le) exp_lo = rl;
  endfunction

  function automatic logic [W-1:0] rand_operand();
    logic [W-1:0] r;
    case ($urandom_range(0, 7))
      0: r = '0;
      1: r = 32'h8000_0000;
      2: r = '1;
      3: r = 32'd1;
      4, 5: begin
        r = W'($urandom_range(0, 40));
        if ($urandom_range(0, 1) == 1) r = -r;
      end
      default: r = $urandom;
    endcase
    return r;
  endfunction

  // Drive a one-cycle start from the current negedge; operands are scrambled
  // afterwards so any failure to latch them shows up.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic he, input logic le);
    start = 1'b1; alucontrol = op; srca = a; srcb = b; hien = he; loen = le;
    @(negedge clk);
    start = 1'b0; alucontrol = 4'b0000; srca = $urandom; srcb = $urandom;
    hien = $urandom_range(0, 1); loen = $urandom_range(0, 1);
  endtask

  task automatic wait_done(output int bc, output bit ok);
    bc = 0;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (busy) bc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== '0 || lo !== '0) begin
      n_fail++;
      $display("FAIL reset_values: busy=%b done=%b hi=%h lo=%h, required 0 0 0 0", busy, done, hi, lo);
    end
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== '0 || lo !== '0) begin
      n_fail++;
      $display("FAIL reset_release: busy=%b done=%b hi=%h lo=%h, required 0 0 0 0", busy, done, hi, lo);
    end
  endtask

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a, b, rh, rl;
  } vec_t;

  task automatic test_directed();
    vec_t v [5];
    int bc, lat;
    bit ok;
    v[0] = '{OP_MULT, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    v[1] = '{OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    v[2] = '{OP_DIV, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF};
    v[3] = '{OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000};
    v[4] = '{OP_MULT, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0};
    for (int i = 0; i < 5; i++) begin
      lat = (v[i].op == OP_MULT) ? MUL_LAT : DIV_LAT;
      @(negedge clk);
      issue(v[i].op, v[i].a, v[i].b, 1'b1, 1'b1);
      wait_done(bc, ok);
      exp_hi = v[i].rh;
      exp_lo = v[i].rl;
      n_checks++;
      if (!ok || bc != lat) begin
        n_fail++;
        $display("FAIL directed_latency[%0d]: busy cycles %0d done=%0b, required %0d cycles then done", i, bc, ok, lat);
      end
      n_checks++;
      if (hi !== v[i].rh || lo !== v[i].rl) begin
        n_fail++;
        $display("FAIL directed_result[%0d]: hi=%h lo=%h, required hi=%h lo=%h", i, hi, lo, v[i].rh, v[i].rl);
      end
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL directed_done_pulse[%0d]: done=%b busy=%b one cycle later, required 0 0", i, done, busy);
      end
    end
  endtask

  task automatic test_mult_random();
    int bc;
    bit ok;
    logic [W-1:0] a, b;
    for (int i = 0; i < 12; i++) begin
      a = rand_operand();
      b = rand_operand();
      @(negedge clk);
      model_op(OP_MULT, a, b, 1'b1, 1'b1);
      issue(OP_MULT, a, b, 1'b1, 1'b1);
      wait_done(bc, ok);
      n_checks++;
      if (!ok || bc != MUL_LAT) begin
        n_fail++;
        $display("FAIL mult_latency: a=%h b=%h busy cycles %0d done=%0b, required %0d", a, b, bc, ok, MUL_LAT);
      end
      n_checks++;
      if (hi !== exp_hi || lo !== exp_lo) begin
        n_fail++;
        $display("FAIL mult_result: a=%h b=%h got hi=%h lo=%h, required hi=%h lo=%h", a, b, hi, lo, exp_hi, exp_lo);
      end
    end
  endtask

  task automatic test_div_random();
    int bc;
    bit ok;
    logic [W-1:0] a, b;
    for (int i = 0; i < 14; i++) begin
      a = rand_operand();
      b = rand_operand();
      @(negedge clk);
      model_op(OP_DIV, a, b, 1'b1, 1'b1);
      issue(OP_DIV, a, b, 1'b1, 1'b1);
      wait_done(bc, ok);
      n_checks++;
      if (!ok || bc != DIV_LAT) begin
        n_fail++;
        $display("FAIL div_latency: a=%h b=%h busy cycles %0d done=%0b, required %0d", a, b, bc, ok, DIV_LAT);
      end
      n_checks++;
      if (hi !== exp_hi || lo !== exp_lo) begin
        n_fail++;
        $display("FAIL div_result: a=%h b=%h got hi=%h lo=%h, required hi=%h lo=%h", a, b, hi, lo, exp_hi, exp_lo);
      end
    end
  endtask

  task automatic test_enables();
    int bc;
    bit ok;
    logic [3:0] op;
    logic [W-1:0] a, b;
    logic he, le;
    for (int i = 0; i < 8; i++) begin
      op = ($urandom_range(0, 1) == 1) ? OP_DIV : OP_MULT;
      a  = $urandom;
      b  = rand_operand();
      he = i[0];
      le = i[1];
      @(negedge clk);
      model_op(op, a, b, he, le);
      issue(op, a, b, he, le);
      wait_done(bc, ok);
      n_checks++;
      if (!ok || hi !== exp_hi || lo !== exp_lo) begin
        n_fail++;
        $display("FAIL enables: op=%b hien=%b loen=%b done=%0b got hi=%h lo=%h, required hi=%h lo=%h",
                 op, he, le, ok, hi, lo, exp_hi, exp_lo);
      end
    end
  endtask

  task automatic test_start_while_busy_flush();
    bit seen_done;
    bit bad_idle;
    seen_done = 1'b0;
    @(negedge clk);
    issue(LONG_OP, 32'd3, 32'd4, 1'b1, 1'b1);
    for (int c = 1; c <= 12; c++) begin
      if (done) seen_done = 1'b1;
      if (c == 5) begin
        start = 1'b1; alucontrol = OP_DIV; srca = 32'd100; srcb = 32'd7; hien = 1'b1; loen = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (c == 12) flush = 1'b1;
      @(negedge clk);
    end
    flush = 1'b0;
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || seen_done) begin
      n_fail++;
      $display("FAIL flush_busy: busy=%b done=%b earlier done=%0b, required 0 0 0", busy, done, seen_done);
    end
    n_checks++;
    if (hi !== exp_hi || lo !== exp_lo) begin
      n_fail++;
      $display("FAIL flush_hold: hi=%h lo=%h, required unchanged hi=%h lo=%h", hi, lo, exp_hi, exp_lo);
    end
    bad_idle = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (busy !== 1'b0 || done !== 1'b0) bad_idle = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (bad_idle || hi !== exp_hi || lo !== exp_lo) begin
      n_fail++;
      $display("FAIL ignored_start: activity after flush=%0b hi=%h lo=%h, required 0 hi=%h lo=%h",
               bad_idle, hi, lo, exp_hi, exp_lo);
    end
  endtask

  task automatic test_flush_fix();
    @(negedge clk);
    issue(OP_DIV, 32'hFFFF_FF9C, 32'd7, 1'b1, 1'b1);
    // Negedge DIV_LAT after the accepting edge is the FIX cycle.
    for (int c = 1; c < DIV_LAT; c++) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== exp_hi || lo !== exp_lo) begin
      n_fail++;
      $display("FAIL flush_in_fix: busy=%b done=%b hi=%h lo=%h, required 0 0 hi=%h lo=%h",
               busy, done, hi, lo, exp_hi, exp_lo);
    end
    start = 1'b1; flush = 1'b1; alucontrol = OP_MULT; srca = 32'd9; srcb = 32'd9;
    @(negedge clk);
    start = 1'b0; flush = 1'b0; alucontrol = 4'b0000;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_with_start: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    issue(OP_DIV, 32'h1234_5678, 32'd3, 1'b1, 1'b1);
    repeat (10) @(negedge clk);
    reset = 1'b0;
    #1;
    exp_hi = '0;
    exp_lo = '0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== exp_hi || lo !== exp_lo) begin
      n_fail++;
      $display("FAIL reset_mid_op: busy=%b done=%b hi=%h lo=%h, required 0 0 0 0", busy, done, hi, lo);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || hi !== exp_hi || lo !== exp_lo) begin
      n_fail++;
      $display("FAIL reset_mid_after: busy=%b hi=%h lo=%h, required 0 0 0", busy, hi, lo);
    end
  endtask

  task automatic test_back_to_back();
    int bc, lat;
    bit ok;
    logic [3:0] op;
    logic [W-1:0] a, b;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      op  = i[0] ? OP_DIV : OP_MULT;
      a   = rand_operand();
      b   = rand_operand();
      lat = (op == OP_MULT) ? MUL_LAT : DIV_LAT;
      model_op(op, a, b, 1'b1, 1'b1);
      issue(op, a, b, 1'b1, 1'b1);
      wait_done(bc, ok);
      n_checks++;
      if (!ok || bc != lat || hi !== exp_hi || lo !== exp_lo) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: op=%b a=%h b=%h cycles %0d done=%0b hi=%h lo=%h, required %0d hi=%h lo=%h",
                 i, op, a, b, bc, ok, hi, lo, lat, exp_hi, exp_lo);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_mult_random();
    test_div_random();
    test_enables();
    test_start_while_busy_flush();
    test_flush_fix();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
